// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, decodes the
// latched instruction into datapath controls and traps on illegal opcodes or memory timeouts.
module multicycle_control_fsm #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            mem_req,
    output logic [3:0]      alu_op,
    output logic [2:0]      branch_type,
    output logic            reg_write_en,
    output logic            alu_mux_en,
    output logic            mem_to_reg,
    output logic            load_byte,
    output logic            store_byte,
    output logic            read_mem,
    output logic            write_mem,
    output logic            pc_absolute_jump_vec,
    output logic            read_next_pc,
    output logic            ir_write_en,
    output logic            pc_write_en,
    output logic            instr_retired,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL,
        C_OP,
        C_OPIMM,
        C_LUI,
        C_AUIPC,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR
    } iclass_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JUMP = 3'd7;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_FETCH   = 2'd2;
    localparam logic [1:0] CAUSE_DATA    = 2'd3;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [31:0]     ir_q;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    iclass_t    cls;

    logic [3:0] dec_alu;
    logic [2:0] dec_bt;
    logic       dec_mux, dec_abs, dec_lb, dec_sb, br_ok;
    logic       drive_dec;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign alt    = ir_q[30];

    logic unused_ir;
    assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    if (XLEN > 32) begin : g_wide
        logic unused_hi;
        assign unused_hi = ^mem_rdata[XLEN-1:32];
    end

    always_comb begin
        cls = C_ILLEGAL;
        case (opcode)
            7'b0110011: cls = C_OP;
            7'b0010011: cls = C_OPIMM;
            7'b0110111: cls = C_LUI;
            7'b0010111: cls = C_AUIPC;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b1100011: cls = C_BRANCH;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            default:    cls = C_ILLEGAL;
        endcase
    end

    // Decoded controls are a pure function of ir_q, keeping mem_rdata off every control path.
    always_comb begin
        dec_alu = ALU_ADD;
        dec_bt  = BR_NONE;
        dec_mux = 1'b0;
        dec_abs = 1'b0;
        dec_lb  = 1'b0;
        dec_sb  = 1'b0;
        br_ok   = 1'b0;
        case (cls)
            C_OP, C_OPIMM: begin
                dec_mux = (cls == C_OPIMM);
                case (funct3)
                    3'b000:  dec_alu = (cls == C_OP && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_alu = ALU_SLL;
                    3'b010:  dec_alu = ALU_SLT;
                    3'b011:  dec_alu = ALU_SLTU;
                    3'b100:  dec_alu = ALU_XOR;
                    3'b101:  dec_alu = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_alu = ALU_OR;
                    default: dec_alu = ALU_AND;
                endcase
            end
            C_LUI: begin
                dec_alu = ALU_PASSB;
                dec_mux = 1'b1;
            end
            C_AUIPC: dec_mux = 1'b1;
            C_LOAD: begin
                dec_mux = 1'b1;
                dec_lb  = (funct3 == 3'b000) || (funct3 == 3'b100);
            end
            C_STORE: begin
                dec_mux = 1'b1;
                dec_sb  = (funct3 == 3'b000);
            end
            C_BRANCH: begin
                br_ok = 1'b1;
                case (funct3)
                    3'b000:  dec_bt = BR_BEQ;
                    3'b001:  dec_bt = BR_BNE;
                    3'b100:  dec_bt = BR_BLT;
                    3'b101:  dec_bt = BR_BGE;
                    3'b110:  dec_bt = BR_BLTU;
                    3'b111:  dec_bt = BR_BGEU;
                    default: br_ok  = 1'b0;
                endcase
            end
            C_JAL: dec_bt = BR_JUMP;
            C_JALR: begin
                dec_bt  = BR_JUMP;
                dec_abs = 1'b1;
                dec_mux = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d              = state_q;
        cnt_d                = '0;
        cause_d              = cause_q;
        mem_req              = 1'b0;
        alu_op               = ALU_ADD;
        branch_type          = BR_NONE;
        reg_write_en         = 1'b0;
        alu_mux_en           = 1'b0;
        mem_to_reg           = 1'b0;
        load_byte            = 1'b0;
        store_byte           = 1'b0;
        read_mem             = 1'b0;
        write_mem            = 1'b0;
        pc_absolute_jump_vec = 1'b0;
        read_next_pc         = 1'b0;
        ir_write_en          = 1'b0;
        pc_write_en          = 1'b0;
        instr_retired        = 1'b0;
        trap                 = 1'b0;
        trap_cause           = cause_q;

        drive_dec = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
        if (drive_dec) begin
            alu_op               = dec_alu;
            branch_type          = dec_bt;
            alu_mux_en           = dec_mux;
            pc_absolute_jump_vec = dec_abs;
        end

        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                read_mem = 1'b1;
                if (mem_ack) begin
                    ir_write_en = 1'b1;
                    state_d     = S_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_FETCH;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                if (cls == C_ILLEGAL) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH: begin
                        if (br_ok) begin
                            pc_write_en   = 1'b1;
                            instr_retired = 1'b1;
                            state_d       = S_FETCH;
                        end else begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILLEGAL;
                        end
                    end
                    C_OP, C_OPIMM, C_LUI, C_AUIPC, C_JAL, C_JALR: state_d = S_WB;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (cls == C_LOAD) begin
                    read_mem  = 1'b1;
                    load_byte = dec_lb;
                end else begin
                    write_mem  = 1'b1;
                    store_byte = dec_sb;
                end
                if (mem_ack) begin
                    if (cls == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write_en   = 1'b1;
                        instr_retired = 1'b1;
                        state_d       = S_FETCH;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DATA;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                reg_write_en  = 1'b1;
                pc_write_en   = 1'b1;
                instr_retired = 1'b1;
                mem_to_reg    = (cls == C_LOAD);
                load_byte     = dec_lb;
                read_next_pc  = (cls == C_JAL) || (cls == C_JALR);
                state_d       = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
            end
        endcase

        // Outputs are forced quiet while reset is held so an aborted transaction never retires.
        if (!nrst) begin
            mem_req              = 1'b0;
            alu_op               = ALU_ADD;
            branch_type          = BR_NONE;
            reg_write_en         = 1'b0;
            alu_mux_en           = 1'b0;
            mem_to_reg           = 1'b0;
            load_byte            = 1'b0;
            store_byte           = 1'b0;
            read_mem             = 1'b0;
            write_mem            = 1'b0;
            pc_absolute_jump_vec = 1'b0;
            read_next_pc         = 1'b0;
            ir_write_en          = 1'b0;
            pc_write_en          = 1'b0;
            instr_retired        = 1'b0;
            trap                 = 1'b0;
            trap_cause           = CAUSE_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (ir_write_en) begin
                ir_q <= mem_rdata[31:0];
            end
        end
    end

endmodule
